lut_neuron_sequencer: RTL and testbench

Time-multiplexing controller that shares one reconfigurable LUT-neuron table memory (NEURONS tables × 2^IN_BITS entries × OUT_BITS) across all neurons of a layer. It accepts a vector of pre-gathered per-neuron fan-in addresses and issues one table lookup per neuron per cycle. It collects the results into an output vector and returns it over a valid/ready handshake. It also arbitrates the shared memory port between the lookup sequencer and a table-configuration write port.

---
 rtl/lut_neuron_sequencer.sv | 111 +++++++++++
 tb/tb_lut_neuron_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_sequencer.sv
// Shares one LUT-neuron table memory across a layer: one lookup per neuron per cycle,
// results gathered into an output vector; config writes own the port while idle.
module lut_neuron_sequencer #(
  parameter int NEURONS  = 16,
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2,
  parameter int IDX_W    = $clog2(NEURONS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [NEURONS*IN_BITS-1:0]    s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [NEURONS*OUT_BITS-1:0]   m_data,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [IDX_W+IN_BITS-1:0]      cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_data,
  output logic [IDX_W+IN_BITS-1:0]      lut_addr,
  output logic                          lut_rd_en,
  input  logic [OUT_BITS-1:0]           lut_rd_data,
  output logic                          lut_we,
  output logic [OUT_BITS-1:0]           lut_wr_data,
  output logic                          busy,
  output logic [1:0]                    state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // ready never depends on the same-channel valid, and m_valid/m_data hold until m_ready.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [NEURONS*IN_BITS-1:0]    in_buf_q, in_buf_d;
  logic [NEURONS*OUT_BITS-1:0]   out_buf_q;
  logic                          rd_en_d_q;
  logic [IDX_W-1:0]              cap_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      in_buf_q  <= '0;
      out_buf_q <= '0;
      rd_en_d_q <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      in_buf_q  <= in_buf_d;
      rd_en_d_q <= lut_rd_en;
      cap_idx_q <= idx_q;
      // Read data arrives one cycle after its strobe, so it lands under the delayed index.
      if (rd_en_d_q) begin
        out_buf_q[cap_idx_q*OUT_BITS +: OUT_BITS] <= lut_rd_data;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_buf_d    = in_buf_q;
    s_ready     = 1'b0;
    cfg_ready   = 1'b0;
    m_valid     = 1'b0;
    lut_rd_en   = 1'b0;
    lut_we      = 1'b0;
    lut_addr    = '0;
    lut_wr_data = '0;
    case (state_q)
      IDLE: begin
        // Config wins over a new input vector; both ports are closed while rst is held.
        cfg_ready = !rst;
        s_ready   = !rst && !cfg_valid;
        if (cfg_valid && cfg_ready) begin
          lut_we      = 1'b1;
          lut_addr    = cfg_addr;
          lut_wr_data = cfg_data;
        end else if (s_valid && s_ready) begin
          in_buf_d = s_data;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        lut_rd_en = 1'b1;
        lut_addr  = {idx_q, in_buf_q[idx_q*IN_BITS +: IN_BITS]};
        if (idx_q == IDX_W'(NEURONS-1)) begin
          idx_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: state_d = OUT;
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_data    = out_buf_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_lut_neuron_sequencer.sv
// Bench for lut_neuron_sequencer: memory model, directed vectors, scoreboard with
// an expected-result queue popped by a monitor on each output handshake.
module tb_lut_neuron_sequencer;
  localparam int N  = 16;
  localparam int IB = 8;
  localparam int OB = 2;
  localparam int AW = 12;
  localparam int SW = N*IB;
  localparam int DW = N*OB;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          s_valid = 0, s_ready, m_valid, m_ready = 1, cfg_valid = 0, cfg_ready;
  logic [SW-1:0] s_data = '0;
  logic [DW-1:0] m_data;
  logic [AW-1:0] cfg_addr = '0, lut_addr;
  logic [OB-1:0] cfg_data = '0, lut_wr_data, lut_rd_data = '0;
  logic          lut_rd_en, lut_we, busy;
  logic [1:0]    state_dbg;

  lut_neuron_sequencer dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .lut_addr(lut_addr), .lut_rd_en(lut_rd_en), .lut_rd_data(lut_rd_data),
    .lut_we(lut_we), .lut_wr_data(lut_wr_data), .busy(busy), .state_dbg(state_dbg)
  );

  // table memory with one-cycle read latency
  logic [OB-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (lut_we) mem[lut_addr] <= lut_wr_data;
    lut_rd_data <= lut_rd_en ? mem[lut_addr] : '0;
  end

  // scoreboard
  int            checks = 0, failures = 0;
  logic [OB-1:0] gold [0:(1<<AW)-1];
  logic [DW-1:0] exp_q[$];
  int            e0_q[$];
  logic [SW-1:0] cur_vec = '0;
  int            rd_k = 0;
  logic          mv_prev = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] exp_of(logic [SW-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*OB +: OB] = gold[k*256 + int'(v[k*IB +: IB])];
    return r;
  endfunction

  function automatic logic [SW-1:0] make_vec(int mul, int off);
    logic [SW-1:0] v;
    for (int k = 0; k < N; k++) v[k*IB +: IB] = 8'((k*mul + off) % 256);
    return v;
  endfunction

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      mv_prev = 1'b0;
    end else begin
      chk("rd_we_exclusive", {63'd0, lut_rd_en & lut_we}, 64'd0);
      if (lut_rd_en) begin
        chk("rd_addr_seq", 64'(lut_addr), 64'({rd_k[3:0], cur_vec[rd_k*IB +: IB]}));
        rd_k++;
      end
      if (m_valid && !mv_prev) begin
        if (e0_q.size() == 0) chk("unexpected_m_valid", 64'd1, 64'd0);
        else chk("latency", 64'(cyc - e0_q.pop_front()), 64'd17);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 64'd1, 64'd0);
        else chk("m_data", 64'(m_data), 64'(exp_q.pop_front()));
      end
      mv_prev = m_valid;
    end
  end

  // drivers (entered and left #1 after a rising edge)
  task automatic send_vec(input logic [SW-1:0] v, output int e0);
    bit hs = 0;
    int n = 0;
    e0 = -1;
    s_valid = 1'b1;
    s_data  = v;
    while (!hs && n < 200) begin
      @(negedge clk);
      if (s_ready) begin
        hs = 1;
        e0 = cyc + 1;
        exp_q.push_back(exp_of(v));
        e0_q.push_back(e0);
        cur_vec = v;
        rd_k = 0;
      end
      @(posedge clk); #1;
      n++;
    end
    s_valid = 1'b0;
    if (!hs) chk("s_handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic cfg_write(input int addr, input logic [OB-1:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = AW'(addr);
    cfg_data  = data;
    @(negedge clk);
    chk("cfg_ready", 64'(cfg_ready), 64'd1);
    chk("cfg_we", 64'(lut_we), 64'd1);
    chk("cfg_addr_out", 64'(lut_addr), 64'(addr));
    gold[addr] = data;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      e0_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, prev_e0, c0, wr_cnt, n;
    for (int a = 0; a < (1<<AW); a++) gold[a] = '0;

    // reset asserted mid-cycle with a pending config write
    #2;
    cfg_valid = 1'b1; cfg_addr = 12'h123; cfg_data = 2'b10; s_valid = 1'b1;
    #6 rst = 1'b1;
    #1;
    chk("rst_m_valid", 64'(m_valid), 0);
    chk("rst_s_ready", 64'(s_ready), 0);
    chk("rst_cfg_ready", 64'(cfg_ready), 0);
    chk("rst_lut_we", 64'(lut_we), 0);
    chk("rst_lut_rd_en", 64'(lut_rd_en), 0);
    chk("rst_lut_addr", 64'(lut_addr), 0);
    chk("rst_lut_wr_data", 64'(lut_wr_data), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_m_data", 64'(m_data), 0);
    repeat (2) @(posedge clk);
    #1;
    cfg_valid = 1'b0; s_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("idle_s_ready", 64'(s_ready), 1);
    chk("idle_busy", 64'(busy), 0);
    @(posedge clk); #1;

    // full table: entry value (neuron+entry)%4
    for (int a = 0; a < (1<<AW); a++) cfg_write(a, 2'((a/256 + a%256) % 4));
    cfg_valid = 1'b0;

    // directed vectors
    send_vec(make_vec(3, 0), e0);   wait_drain();
    send_vec(make_vec(5, 1), e0);   wait_drain();
    send_vec(make_vec(7, 200), e0); wait_drain();

    // backpressure in OUT with both inputs pushing
    m_ready = 1'b0;
    send_vec(make_vec(11, 3), e0);
    n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < 40);
    chk("bp_reach_out", 64'(m_valid), 1);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = make_vec(1, 9);
    cfg_valid = 1'b1; cfg_addr = '0; cfg_data = gold[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_m_valid", 64'(m_valid), 1);
      chk("bp_m_data", 64'(m_data), 64'(exp_q.size() > 0 ? exp_q[0] : '1));
      chk("bp_s_ready", 64'(s_ready), 0);
      chk("bp_cfg_ready", 64'(cfg_ready), 0);
      chk("bp_lut_we", 64'(lut_we), 0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    chk("bp_back_idle", 64'(busy), 0);
    chk("bp_m_valid_drop", 64'(m_valid), 0);
    @(posedge clk); #1;

    // arbitration: three config writes win, input accepted on the 4th edge
    s_valid = 1'b1; s_data = make_vec(3, 0);
    wr_cnt = 0; c0 = -1;
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_addr = AW'(i*256 + i*3); cfg_data = 2'd3;
      @(negedge clk);
      if (i == 0) c0 = cyc;
      chk("arb_s_ready", 64'(s_ready), 0);
      if (lut_we) wr_cnt++;
      gold[i*256 + i*3] = 2'd3;
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    chk("arb_writes", 64'(wr_cnt), 3);
    send_vec(make_vec(3, 0), e0);
    chk("arb_hs_edge", 64'(e0), 64'(c0 + 4));
    wait_drain();

    // reset in the middle of RUN
    send_vec(make_vec(13, 17), e0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(lut_rd_en && lut_addr[11:8] == 4'd7) && n < 40);
    chk("mid_reach_idx7", 64'(lut_addr[11:8]), 7);
    #2 rst = 1'b1;
    exp_q.delete(); e0_q.delete();
    #1;
    chk("mid_rst_rd_en", 64'(lut_rd_en), 0);
    chk("mid_rst_m_valid", 64'(m_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("post_rst_rd_en", 64'(lut_rd_en), 0);
      chk("post_rst_m_valid", 64'(m_valid), 0);
    end
    @(posedge clk); #1;
    send_vec(make_vec(9, 40), e0); wait_drain();

    // throughput: four back-to-back vectors
    prev_e0 = -1;
    for (int i = 0; i < 4; i++) begin
      send_vec(make_vec(2*i + 1, 31*i + 5), e0);
      if (i > 0) chk("throughput_spacing", 64'(e0 - prev_e0), 19);
      prev_e0 = e0;
    end
    wait_drain();
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
